// File: rtl/sar_search.sv
// Purpose: successive-approximation search; drives comparator `a` (trial) and
//          reads its l/e/g outputs to recover the unknown value on `b`.
// Latency: k cycles on equality at probe k, W+1 cycles for a full search; no backpressure.
//
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   start            begin a search (only sampled while idle)
//   l, e, g          comparator outputs for the current trial
//   trial            registered trial value driven to comparator `a`
//   busy             search in progress
//   done             one-cycle pulse when a search ends
//   result, found    recovered value and equality confirmation, held until next start
module sar_search #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         l,
    input  logic         e,
    input  logic         g,
    output logic [W-1:0] trial,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         found
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PROBE  = 2'd1,
        VERIFY = 2'd2
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_d;
    logic [IW-1:0] idx_m1;
    logic [W-1:0]  trial_d;
    logic [W-1:0]  trial_adj;
    logic [W-1:0]  result_d;
    logic          found_d;
    logic          busy_d;
    logic          done_d;
    logic          legal;

    // A healthy comparator asserts exactly one of l/e/g.
    assign legal = ({l, e, g} == 3'b100) ||
                   ({l, e, g} == 3'b010) ||
                   ({l, e, g} == 3'b001);

    assign idx_m1 = idx - 1'b1;

    // Bit decision for the current probe: a too-large trial drops the bit under
    // test, then the next lower bit is tentatively set. Only bit set/clear.
    always_comb begin
        trial_adj = trial;
        if (g) begin
            trial_adj[idx] = 1'b0;
        end
        if (idx != '0) begin
            trial_adj[idx_m1] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        trial_d  = trial;
        result_d = result;
        found_d  = found;
        busy_d   = busy;
        done_d   = 1'b0;

        case (state)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    trial_d = '0;
                    trial_d[W-1] = 1'b1;
                    idx_d   = IW'(W - 1);
                    busy_d  = 1'b1;
                    state_d = PROBE;
                end
            end

            PROBE: begin
                if (!legal) begin
                    // Broken comparator: report where we stopped, unconfirmed.
                    result_d = trial;
                    found_d  = 1'b0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else if (e) begin
                    result_d = trial;
                    found_d  = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    trial_d = trial_adj;
                    if (idx != '0) begin
                        idx_d = idx_m1;
                    end else begin
                        // LSB decided; one more cycle to let the comparator
                        // confirm the final value.
                        state_d = VERIFY;
                    end
                end
            end

            VERIFY: begin
                result_d = trial;
                found_d  = e && legal;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            trial  <= '0;
            result <= '0;
            found  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            idx    <= idx_d;
            trial  <= trial_d;
            result <= result_d;
            found  <= found_d;
            busy   <= busy_d;
            done   <= done_d;
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: randomized and directed searches against a comparator
// model with fault modes; expected trials/results queued, checked by a monitor.
module tb_sar_search;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         l;
    logic         e;
    logic         g;
    logic [W-1:0] trial;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         found;

    int target = 0;
    int fmode  = 0;    // 0 real comparator, 1 g stuck high, 2 all outputs low

    typedef struct {
        int res;
        int fnd;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    int   trial_q[$];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    int bcnt   = 0;

    sar_search #(.W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .l      (l),
        .e      (e),
        .g      (g),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result),
        .found  (found)
    );

    always #5 clk = ~clk;

    // Comparator seen on the `b` side, plus injected faults.
    always_comb begin
        l = 1'b0;
        e = 1'b0;
        g = 1'b0;
        case (fmode)
            0: begin
                l = int'(trial) < target;
                e = int'(trial) == target;
                g = int'(trial) > target;
            end
            1: g = 1'b1;
            default: ;
        endcase
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: probe k of a binary search holds the target's top k-1 bits
    // followed by a single 1; the search stops at the first probe equal to the
    // target, otherwise a final verify cycle shows the target itself.
    task automatic push_expect(input int t, input int mode, output int lat);
        exp_t x;
        int   p;
        bit   hit;
        hit = 1'b0;
        if (mode == 0) begin
            for (int k = 1; k <= W && !hit; k++) begin
                p = ((t >> (W - k + 1)) << (W - k + 1)) | (1 << (W - k));
                trial_q.push_back(p);
                if (p == t) begin
                    hit = 1'b1;
                    x.res = t; x.fnd = 1; x.lat = k;
                end
            end
            if (!hit) begin
                trial_q.push_back(t);
                x.res = t; x.fnd = 1; x.lat = W + 1;
            end
        end else if (mode == 1) begin
            for (int k = 1; k <= W; k++) trial_q.push_back(1 << (W - k));
            trial_q.push_back(0);
            x.res = 0; x.fnd = 0; x.lat = W + 1;
        end else begin
            trial_q.push_back(1 << (W - 1));
            x.res = 1 << (W - 1); x.fnd = 0; x.lat = 1;
        end
        exp_q.push_back(x);
        lat = x.lat;
    endtask

    // Monitor: compares every busy-cycle trial and every done pulse.
    always @(negedge clk) begin
        if (!mon_en) begin
            bcnt = 0;
        end else begin
            if (busy) begin
                bcnt++;
                if (trial_q.size() == 0) begin
                    chk("unexpected_busy", 1, 0);
                end else begin
                    chk("trial", int'(trial), trial_q.pop_front());
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    chk("result", int'(result), x.res);
                    chk("found", int'(found), x.fnd);
                    chk("latency", bcnt, x.lat);
                end
                bcnt = 0;
            end
        end
    end

    task automatic wait_done();
        int n;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        chk("done_timeout", (n < 20) ? 1 : 0, 1);
    endtask

    task automatic do_search(input int t, input int mode, input bit pulse);
        int lat;
        target = t;
        fmode  = mode;
        push_expect(t, mode, lat);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (pulse && lat >= 4) begin
            repeat ($urandom_range(0, 1)) @(posedge clk);
            @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_trial", int'(trial), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_found", int'(found), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases from the block description.
        do_search(16, 0, 1'b0);
        repeat (3) @(negedge clk);
        chk("hold_result", int'(result), 16);
        chk("hold_found", int'(found), 1);
        chk("hold_trial", int'(trial), 16);
        do_search(21, 0, 1'b1);
        do_search(0, 0, 1'b0);
        do_search(9, 1, 1'b0);
        do_search(9, 2, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Reset at the third probe: outputs clear, no done pulse.
        mon_en = 1'b0;
        target = 21;
        fmode  = 0;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_rst_trial", int'(trial), 20);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_trial", int'(trial), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_result", int'(result), 0);
        chk("midrst_found", int'(found), 0);
        // Start together with reset: reset wins.
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_vs_start_busy", int'(busy), 0);
        start  = 1'b0;
        rst_n  = 1'b1;
        @(posedge clk);
        #1 mon_en = 1'b1;

        // Randomized targets with occasional ignored start pulses.
        for (int i = 0; i < 40; i++) begin
            do_search(int'($urandom_range(0, 31)), 0, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Exhaustive sweep with start held high between searches.
        fmode = 0;
        start = 1'b1;
        for (int t = 0; t < 32; t++) begin
            int lat;
            target = t;
            push_expect(t, 0, lat);
            wait_done();
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("trial_q_empty", trial_q.size(), 0);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
